// File: rtl/music_sequencer_pkg.sv
// rtl/music_sequencer_pkg.sv - shared types, note constants and pitch helpers for music_sequencer
//
// Purpose: sequencer state encoding, special note byte values, the semitone
//          divider table and the octave/note split of a 6-bit pitch.
// Ports:   none (package)
package music_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_t;

    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [7:0] NOTE_END  = 8'hFF;

    // Semitone divider, A..G#, lowest octave.
    function automatic logic [8:0] note_divider(input logic [3:0] note);
        case (note)
            4'd0:    return 9'd511;
            4'd1:    return 9'd482;
            4'd2:    return 9'd455;
            4'd3:    return 9'd430;
            4'd4:    return 9'd405;
            4'd5:    return 9'd383;
            4'd6:    return 9'd361;
            4'd7:    return 9'd341;
            4'd8:    return 9'd322;
            4'd9:    return 9'd303;
            4'd10:   return 9'd286;
            4'd11:   return 9'd270;
            default: return 9'd0;
        endcase
    endfunction

    // Split a 6-bit pitch into {octave[2:0], note[3:0]}.
    function automatic logic [6:0] divide_by12(input logic [5:0] pitch);
        return {3'(pitch / 6'd12), 4'(pitch % 6'd12)};
    endfunction

endpackage

// File: rtl/music_sequencer_voice.sv
// rtl/music_sequencer_voice.sv - one square-wave voice driven by a note byte
//
// Purpose: note/octave counters and speaker toggle for a single channel.
// Ports:   clk, reset      clock, asynchronous active-high reset
//          note_byte       current note (8'h00 = rest, bits [7:6] ignored for pitch)
//          enable          counters run (sequencer in PLAY)
//          gate_open       articulation gap over; toggling allowed
//          sync_clear      zero the pitch counters, speaker holds its level
//          kill            force speaker and counters to 0 (idle/stop)
//          speaker         square-wave output
module music_sequencer_voice
    import music_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] note_byte,
    input  logic       enable,
    input  logic       gate_open,
    input  logic       sync_clear,
    input  logic       kill,
    output logic       speaker
);

    logic [6:0] oct_note;
    logic [8:0] divider;
    logic [7:0] oct_reload;
    logic [8:0] cnt_note;
    logic [7:0] cnt_oct;

    assign oct_note   = divide_by12(note_byte[5:0]);
    assign divider    = note_divider(oct_note[3:0]);
    assign oct_reload = 8'hFF >> oct_note[6:4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_note <= '0;
            cnt_oct  <= '0;
            speaker  <= 1'b0;
        end else if (kill) begin
            cnt_note <= '0;
            cnt_oct  <= '0;
            speaker  <= 1'b0;
        end else if (sync_clear) begin
            cnt_note <= '0;
            cnt_oct  <= '0;
        end else if (enable) begin
            cnt_note <= (cnt_note == 9'd0) ? divider : cnt_note - 9'd1;
            if (cnt_note == 9'd0)
                cnt_oct <= (cnt_oct == 8'd0) ? oct_reload : cnt_oct - 8'd1;
            // Counters keep running through the gap so the pitch phase is
            // anchored to the start of the step, not to the end of the gap.
            if (!gate_open || note_byte == NOTE_REST)
                speaker <= 1'b0;
            else if (cnt_note == 9'd0 && cnt_oct == 8'd0)
                speaker <= ~speaker;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// rtl/music_sequencer.sv - polyphonic note-ROM sequencer driving square-wave speakers
//
// Purpose: steps through an external note ROM, one word per step, and plays
//          CHANNELS voices with start/stop, loop and end-of-song handling.
// Ports:   clk, reset      clock, asynchronous active-high reset
//          start, stop     1-cycle control strobes (stop wins)
//          loop_en         restart at address 0 on the end marker
//          rom_addr/rom_rd ROM read request; rom_data valid one cycle after rom_rd
//          speaker         one square wave per channel
//          busy            not idle
//          done            1-cycle pulse when a non-looping song ends
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int ADDR_W     = 8,
    parameter int STEP_TICKS = 4194304,
    parameter int GAP_TICKS  = 262144
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_rd,
    input  logic [8*CHANNELS-1:0] rom_data,
    output logic [CHANNELS-1:0]   speaker,
    output logic                  busy,
    output logic                  done
);

    localparam int STEP_W = $clog2(STEP_TICKS + 1);

    seq_state_t              state;
    logic [STEP_W-1:0]       step_cnt;
    logic [8*CHANNELS-1:0]   note_q;
    logic                    end_marker;
    logic                    loop_back;
    logic                    voice_kill;

    assign end_marker = (rom_data[7:0] == NOTE_END);
    // An end marker at address 0 means an empty song: never loop on it.
    assign loop_back  = loop_en && (rom_addr != '0);
    // Silence the voices on the same edge the sequencer drops to IDLE.
    assign voice_kill = stop || (state == ST_IDLE) ||
                        (state == ST_LATCH && end_marker && !loop_back);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rom_addr <= '0;
            rom_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            step_cnt <= '0;
            note_q   <= '0;
        end else begin
            done   <= 1'b0;
            rom_rd <= 1'b0;
            if (stop) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                rom_addr <= '0;
                step_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state    <= ST_FETCH;
                            rom_rd   <= 1'b1;
                            busy     <= 1'b1;
                            rom_addr <= '0;
                            step_cnt <= '0;
                        end
                    end
                    ST_FETCH: state <= ST_LATCH;
                    ST_LATCH: begin
                        if (end_marker) begin
                            rom_addr <= '0;
                            if (loop_back) begin
                                state  <= ST_FETCH;
                                rom_rd <= 1'b1;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            note_q   <= rom_data;
                            step_cnt <= '0;
                            state    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (step_cnt == STEP_W'(STEP_TICKS - 1)) begin
                            step_cnt <= '0;
                            rom_addr <= rom_addr + ADDR_W'(1);
                            rom_rd   <= 1'b1;
                            state    <= ST_FETCH;
                        end else begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_voice
        music_sequencer_voice u_voice (
            .clk        (clk),
            .reset      (reset),
            .note_byte  (note_q[8*i +: 8]),
            .enable     (state == ST_PLAY),
            .gate_open  (step_cnt >= STEP_W'(GAP_TICKS)),
            .sync_clear (state == ST_LATCH),
            .kill       (voice_kill),
            .speaker    (speaker[i])
        );
    end

endmodule

// File: tb/tb_music_sequencer.sv
// tb/tb_music_sequencer.sv - self-checking bench for music_sequencer
module tb_music_sequencer;

    localparam int STEP = 6144;
    localparam int GAP  = 1024;
    localparam int DIVS [12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [3:0]  rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data = '0;
    logic [1:0]  speaker;
    logic        busy;
    logic        done;

    logic [15:0] rom [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

    music_sequencer #(
        .CHANNELS(2), .ADDR_W(4), .STEP_TICKS(STEP), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .speaker(speaker), .busy(busy), .done(done)
    );

    // Speaker level after the decision at play offset k of a step playing byte b.
    function automatic logic spk(input logic [7:0] b, input int k);
        int p, hp, cnt;
        if (b == 8'h00 || k < GAP) return 1'b0;
        p   = int'(b[5:0]);
        hp  = (DIVS[p % 12] + 1) * ((255 >> (p / 12)) + 1);
        cnt = k / hp - (GAP - 1) / hp;
        return cnt[0];
    endfunction

    function automatic logic [7:0] rand_note();
        logic [7:0] b;
        b = {2'($urandom), 6'($urandom_range(48, 63))};
        if ($urandom_range(0, 3) == 0) b = 8'h00;
        if (b == 8'hFF) b = 8'h3F;
        return b;
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h00FF;
    endtask

    task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed={busy,done,rd,addr,spk}=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Starts a song and compares every cycle against the step-level model.
    task automatic run_song(input bit lp, input int stop_at, input int poke_at, input int max_c);
        int phase, k, c, idle_n;
        logic [3:0]  a;
        logic [1:0]  lvl;
        logic [15:0] cur;
        logic [8:0]  exp_v;
        loop_en = lp;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        phase = 0; k = 0; c = 0; idle_n = 0; a = '0; lvl = '0; cur = '0;
        while (idle_n < 3 && c < max_c) begin
            case (phase)
                0: exp_v = {1'b1, 1'b0, 1'b1, a, lvl};
                1: exp_v = {1'b1, 1'b0, 1'b0, a, lvl};
                2: exp_v = {1'b1, 1'b0, 1'b0, a,
                            (k == 0) ? lvl : {spk(cur[15:8], k - 1), spk(cur[7:0], k - 1)}};
                3: exp_v = {1'b0, 1'b1, 1'b0, 4'd0, 2'b00};
                default: exp_v = '0;
            endcase
            checks++;
            assert ({busy, done, rom_rd, rom_addr, speaker} === exp_v) else begin
                errors++;
                $error("FAIL trace c=%0d phase=%0d observed=%h expected=%h",
                       c, phase, {busy, done, rom_rd, rom_addr, speaker}, exp_v);
            end
            if (c == stop_at) begin
                stop = 1'b1; phase = 4; lvl = '0;
            end else begin
                case (phase)
                    0: phase = 1;
                    1: begin
                        if (rom[a][7:0] == 8'hFF) begin
                            if (lp && a != 4'd0) begin a = '0; phase = 0; end
                            else phase = 3;
                        end else begin
                            cur = rom[a]; k = 0; phase = 2;
                        end
                    end
                    2: begin
                        if (k == STEP - 1) begin
                            lvl = {spk(cur[15:8], k), spk(cur[7:0], k)};
                            a = a + 4'd1; phase = 0;
                        end else k++;
                    end
                    3: phase = 4;
                    default: idle_n++;
                endcase
            end
            if (c == poke_at) start = 1'b1;
            c++;
            @(negedge clk);
            stop = 1'b0; start = 1'b0;
        end
        checks++;
        assert (idle_n >= 3) else begin
            errors++;
            $error("FAIL song_timeout cycles=%0d required_idle=3 observed_idle=%0d", c, idle_n);
        end
    endtask

    initial begin
        logic [15:0] w;
        int len;
        clear_rom();
        repeat (3) @(negedge clk);
        check_vec("reset_state", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);
        reset = 1'b0;
        @(negedge clk);
        check_vec("idle_after_reset", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);

        // Single note on channel 0, channel 1 resting.
        rom[0] = {8'h00, 8'd60};
        run_song(1'b0, -1, -1, 7000);

        // Two notes at once.
        rom[0] = {8'd60, 8'd67};
        run_song(1'b0, -1, -1, 7000);

        // Looping 3-step song, start poked mid-play, stopped in second pass.
        clear_rom();
        rom[0] = {8'd60, 8'd67};
        rom[1] = {8'd00, 8'd55};
        rom[2] = {8'd63, 8'd50};
        run_song(1'b1, 24686, 3000, 30000);

        // Empty song with loop enabled must finish, not spin.
        clear_rom();
        run_song(1'b1, -1, -1, 50);

        // start and stop together: stop wins.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        check_vec("start_stop_same", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);
        @(negedge clk);
        check_vec("start_stop_after", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);

        // Randomized short songs.
        for (int s = 0; s < 2; s++) begin
            clear_rom();
            len = $urandom_range(1, 2);
            for (int i = 0; i < len; i++) begin
                w = {rand_note(), rand_note()};
                rom[i] = w;
            end
            run_song(1'b0, -1, $urandom_range(10, 6000), 15000);
        end

        // Asynchronous reset in the middle of a sounding note.
        clear_rom();
        rom[0] = {8'h00, 8'd60};
        loop_en = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4200) @(negedge clk);
        check_vec("pre_reset_play", {busy, done, rom_rd, rom_addr, speaker}, {1'b1, 1'b0, 1'b0, 4'd0, 2'b01});
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_vec("async_reset", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check_vec("post_reset_idle", {busy, done, rom_rd, rom_addr, speaker}, 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
